// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the synchronous down counter: FSM state codes and
// the counting-mode selector values.
package sync_down_counter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int MODE_FREE    = 0;  // wrap 0 -> all-ones
  localparam int MODE_ONESHOT = 1;  // stop at 0 and hold
  localparam int MODE_RELOAD  = 2;  // reload preset after 0

endpackage

// File: rtl/sync_down_counter_dff_cell.sv
// One counter bit: D flip-flop with synchronous active-low clear and an
// inverted output, shared with the up counter.
module dff_cell
  import sync_down_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_bar
);

  // Capture next bit value; clear when rst is low at the edge.
  always_ff @(posedge clk) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

  assign q_bar = ~q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with terminal-count pulse. Counting bits
// are dff_cell instances fed by a per-bit mux (load / reload / borrow-toggle /
// hold); the FSM, reload register and tc register live here.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bar,
  output logic             tc,
  output logic             busy,
  output logic             zero
);

  localparam bit IS_FREE    = (MODE == MODE_FREE);
  localparam bit IS_ONESHOT = (MODE == MODE_ONESHOT);
  localparam bit IS_RELOAD  = (MODE == MODE_RELOAD);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] d_val;
  logic             cnt_zero;
  logic             cnt_one;
  logic             step;
  logic             dec_now;
  logic             reload_now;
  logic             tc_nxt;

  assign cnt_zero = (count == '0);
  assign cnt_one  = (count == WIDTH'(1));

  // An enabled counting cycle; load always takes precedence over counting.
  assign step = (state == ST_RUN) && en && !load;

  // Free mode wraps by letting the borrow chain roll 0 over to all-ones;
  // one-shot never steps below 0; reload mode swaps in the preset at 0.
  assign dec_now    = step && (!cnt_zero || IS_FREE);
  assign reload_now = step && cnt_zero && IS_RELOAD;

  // tc marks a decrement from 1, plus the degenerate reload-of-zero case
  // where every enabled cycle is a terminal count.
  assign tc_nxt = step && (cnt_one || (cnt_zero && IS_RELOAD && (reload_reg == '0)));

  assign zero = cnt_zero;

  // Borrow chain: bit i toggles when every lower bit is 0.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < WIDTH - 1) begin : g_borrow
      assign borrow[i+1] = borrow[i] & ~count[i];
    end

    assign dec_val[i] = count[i] ^ borrow[i];
    assign d_val[i]   = load       ? load_val[i]   :
                        reload_now ? reload_reg[i] :
                        dec_now    ? dec_val[i]    :
                                     count[i];

    dff_cell u_ff (
      .clk   (clk),
      .rst   (rst),
      .d     (d_val[i]),
      .q     (count[i]),
      .q_bar (count_bar[i])
    );
  end

  // Preset kept for auto-reload; captured on every load.
  always_ff @(posedge clk) begin
    if (!rst)      reload_reg <= '0;
    else if (load) reload_reg <= load_val;
  end

  // Registered terminal-count pulse.
  always_ff @(posedge clk) begin
    if (!rst) tc <= 1'b0;
    else      tc <= tc_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: load enters RUN from anywhere; one-shot parks in HOLD
  // as the count reaches 0 (or immediately if it was loaded with 0).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (load) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!load && IS_ONESHOT && (cnt_zero || (en && cnt_one)))
          state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state == ST_RUN);
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Bench for sync_down_counter: one instance per mode sharing the stimulus,
// an arithmetic reference model checked every cycle, and literal checks of
// the directed scenarios.
module tb_sync_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic       en = 1'b0;

  logic [3:0] cnt    [3];
  logic [3:0] cnt_b  [3];
  logic       tc_o   [3];
  logic       busy_o [3];
  logic       zero_o [3];

  int vectors     = 0;
  int miscompares = 0;
  bit armed       = 1'b0;

  // Reference state per mode
  int m_cnt [3];
  int m_rl  [3];
  bit m_tc  [3];
  bit m_run [3];

  always #5 clk = ~clk;

  sync_down_counter #(.WIDTH(4), .MODE(0)) u_free (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(cnt[0]), .count_bar(cnt_b[0]), .tc(tc_o[0]), .busy(busy_o[0]), .zero(zero_o[0]));

  sync_down_counter #(.WIDTH(4), .MODE(1)) u_oneshot (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(cnt[1]), .count_bar(cnt_b[1]), .tc(tc_o[1]), .busy(busy_o[1]), .zero(zero_o[1]));

  sync_down_counter #(.WIDTH(4), .MODE(2)) u_reload (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(cnt[2]), .count_bar(cnt_b[2]), .tc(tc_o[2]), .busy(busy_o[2]), .zero(zero_o[2]));

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s mode%0d t=%0t got=%h exp=%h", nm, idx, $time, act, exp);
    end
  endtask

  // Reference model: IDLE and HOLD look identical from outside, so only a
  // "running" flag is tracked; counting is plain modulo-16 arithmetic.
  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      int c, r, t, b;
      c = m_cnt[m]; r = m_rl[m]; t = 0; b = m_run[m];
      if (!rst) begin
        c = 0; r = 0; b = 0;
      end else if (load) begin
        c = int'(load_val); r = int'(load_val); b = 1;
      end else if (b == 1 && en) begin
        if (c != 0) begin
          t = (c == 1) ? 1 : 0;
          c = c - 1;
          if (m == 1 && c == 0) b = 0;
        end else if (m == 0) begin
          c = 15;
        end else if (m == 1) begin
          b = 0;
        end else begin
          c = r;
          t = (r == 0) ? 1 : 0;
        end
      end else if (b == 1 && m == 1 && c == 0) begin
        b = 0;
      end
      m_cnt[m] <= c;
      m_rl[m]  <= r;
      m_tc[m]  <= (t != 0);
      m_run[m] <= (b != 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int m = 0; m < 3; m++) begin
        chk("count",     m, cnt[m],           4'(m_cnt[m]));
        chk("count_bar", m, cnt_b[m],         ~4'(m_cnt[m]));
        chk("tc",        m, {3'b0, tc_o[m]},   {3'b0, m_tc[m]});
        chk("busy",      m, {3'b0, busy_o[m]}, {3'b0, m_run[m]});
        chk("zero",      m, {3'b0, zero_o[m]}, {3'b0, (m_cnt[m] == 0)});
      end
    end
  end

  task automatic apply(input logic r, input logic l, input logic [3:0] v, input logic e);
    rst = r; load = l; load_val = v; en = e;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e2c [8] = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0};
  logic [3:0] e2t [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
  logic [3:0] e2b [8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
  logic [3:0] e3c [4] = '{4'h1, 4'h0, 4'hF, 4'hE};
  logic [3:0] e3t [4] = '{4'h0, 4'h1, 4'h0, 4'h0};
  logic [3:0] e4c [7] = '{4'h2, 4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h2};
  logic [3:0] e4t [7] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
  logic [3:0] e5c [4] = '{4'h2, 4'h2, 4'h1, 4'h1};

  initial begin
    // Reset beats load and en
    apply(1'b0, 1'b1, 4'hA, 1'b1);
    armed = 1'b1;
    apply(1'b0, 1'b1, 4'hA, 1'b1);
    for (int m = 0; m < 3; m++) begin
      chk("rst_count", m, cnt[m], 4'h0);
      chk("rst_cbar",  m, cnt_b[m], 4'hF);
      chk("rst_tc",    m, {3'b0, tc_o[m]}, 4'h0);
      chk("rst_busy",  m, {3'b0, busy_o[m]}, 4'h0);
      chk("rst_zero",  m, {3'b0, zero_o[m]}, 4'h1);
    end
    apply(1'b1, 1'b0, 4'h0, 1'b0);

    // One-shot from 5
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, (i == 0), 4'h5, 1'b1);
      chk("os_count", 1, cnt[1], e2c[i]);
      chk("os_tc",    1, {3'b0, tc_o[1]}, e2t[i]);
      chk("os_busy",  1, {3'b0, busy_o[1]}, e2b[i]);
    end

    // Free-running wrap from 1
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, (i == 0), 4'h1, 1'b1);
      chk("wrap_count", 0, cnt[0], e3c[i]);
      chk("wrap_tc",    0, {3'b0, tc_o[0]}, e3t[i]);
    end

    // Auto-reload with preset 2
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, (i == 0), 4'h2, 1'b1);
      chk("rl_count", 2, cnt[2], e4c[i]);
      chk("rl_tc",    2, {3'b0, tc_o[2]}, e4t[i]);
    end

    // Reload mid-count overrides en; then en gating
    apply(1'b1, 1'b1, 4'h9, 1'b1);
    chk("ld9", 0, cnt[0], 4'h9);
    apply(1'b1, 1'b0, 4'h0, 1'b1);
    apply(1'b1, 1'b0, 4'h0, 1'b1);
    chk("at7", 0, cnt[0], 4'h7);
    apply(1'b1, 1'b1, 4'h3, 1'b1);
    chk("reld3", 0, cnt[0], 4'h3);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 4'h0, (i % 2 == 0));
      chk("en_gate", 0, cnt[0], e5c[i]);
    end

    // Reset in the middle of a count
    apply(1'b1, 1'b1, 4'h6, 1'b1);
    chk("ld6", 1, cnt[1], 4'h6);
    apply(1'b0, 1'b0, 4'h0, 1'b1);
    for (int m = 0; m < 3; m++) begin
      chk("mid_rst_count", m, cnt[m], 4'h0);
      chk("mid_rst_busy",  m, {3'b0, busy_o[m]}, 4'h0);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 4'h0, 1'b1);
      for (int m = 0; m < 3; m++) begin
        chk("idle_count", m, cnt[m], 4'h0);
        chk("idle_tc",    m, {3'b0, tc_o[m]}, 4'h0);
      end
    end

    // Load of zero: no tc on load; reload-of-zero holds tc; one-shot parks
    apply(1'b1, 1'b1, 4'h0, 1'b1);
    chk("z_tc",   2, {3'b0, tc_o[2]}, 4'h0);
    chk("z_busy", 1, {3'b0, busy_o[1]}, 4'h1);
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 4'h0, 1'b1);
      chk("z_rl_count", 2, cnt[2], 4'h0);
      chk("z_rl_tc",    2, {3'b0, tc_o[2]}, 4'h1);
      chk("z_os_busy",  1, {3'b0, busy_o[1]}, 4'h0);
      chk("z_os_tc",    1, {3'b0, tc_o[1]}, 4'h0);
    end
    apply(1'b1, 1'b0, 4'h0, 1'b0);
    chk("z_rl_tc_off", 2, {3'b0, tc_o[2]}, 4'h0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
